// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin arbiter that feeds one shared 16-bit ripple
// adder through a two-stage (operand / response) pipeline.

// 16-bit ripple-carry adder; purely combinational.
module ripple_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  logic carry;

  // Propagate the carry bit by bit from LSB to MSB.
  always_comb begin
    sum   = '0;
    carry = ci;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

module adder_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NREQ-1:0]    Req_valid,
  input  logic [16*NREQ-1:0] Req_A,
  input  logic [16*NREQ-1:0] Req_B,
  output logic [NREQ-1:0]    Req_grant,
  output logic               Rsp_valid,
  input  logic               Rsp_ready,
  output logic [IDW-1:0]     Rsp_id,
  output logic [15:0]        Rsp_Sum,
  output logic               Rsp_CO,
  output logic               Busy
);

  // Operand stage (S1)
  logic           s1_v_q, s1_v_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic [15:0]    s1_a_q, s1_a_d;
  logic [15:0]    s1_b_q, s1_b_d;

  // Response stage (S2)
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]    rsp_sum_q, rsp_sum_d;
  logic           rsp_co_q, rsp_co_d;

  // Round-robin pointer: index searched first on the next arbitration.
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           s2_free, s1_adv, s1_free;
  logic           win_found, grant_en;
  logic [IDW-1:0] win_id;
  logic [15:0]    win_a, win_b;
  logic [15:0]    add_sum;
  logic           add_co;

  ripple_adder #(.W(16)) u_adder (
    .a   (s1_a_q),
    .b   (s1_b_q),
    .ci  (1'b0),
    .sum (add_sum),
    .co  (add_co)
  );

  // Pipeline advance conditions; a draining S2 frees S1 in the same cycle.
  always_comb begin
    s2_free = !rsp_valid_q | Rsp_ready;
    s1_adv  = s1_v_q & s2_free;
    s1_free = !s1_v_q | s1_adv;
  end

  // Winner search: first pass covers [ptr, NREQ-1], second pass wraps to
  // [0, ptr-1]. Two passes avoid modulo arithmetic for non-power-of-two NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_a     = '0;
    win_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && Req_valid[i] && (IDW'(i) >= ptr_q)) begin
        win_found = 1'b1;
        win_id    = IDW'(i);
        win_a     = Req_A[16*i +: 16];
        win_b     = Req_B[16*i +: 16];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && Req_valid[i]) begin
        win_found = 1'b1;
        win_id    = IDW'(i);
        win_a     = Req_A[16*i +: 16];
        win_b     = Req_B[16*i +: 16];
      end
    end
  end

  // Mealy grant; gated by Reset_n so nothing is granted while reset is held.
  always_comb begin
    grant_en  = Reset_n & s1_free & win_found;
    Req_grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      Req_grant[i] = grant_en && (win_id == IDW'(i));
    end
  end

  // Next-state for S1, S2 and the pointer.
  always_comb begin
    s1_v_d      = s1_v_q;
    s1_id_d     = s1_id_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_co_d    = rsp_co_q;
    ptr_d       = ptr_q;

    if (grant_en) begin
      s1_v_d  = 1'b1;
      s1_id_d = win_id;
      s1_a_d  = win_a;
      s1_b_d  = win_b;
      ptr_d   = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end

    if (s1_adv) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = s1_id_q;
      rsp_sum_d   = add_sum;
      rsp_co_d    = add_co;
    end else if (Rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers; asynchronous reset discards any in-flight work.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_v_q      <= 1'b0;
      s1_id_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_co_q    <= 1'b0;
      ptr_q       <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_id_q     <= s1_id_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_co_q    <= rsp_co_d;
      ptr_q       <= ptr_d;
    end
  end

  assign Rsp_valid = rsp_valid_q;
  assign Rsp_id    = rsp_id_q;
  assign Rsp_Sum   = rsp_sum_q;
  assign Rsp_CO    = rsp_co_q;
  assign Busy      = s1_v_q | rsp_valid_q;

endmodule

// File: tb/tb_adder_scheduler.sv
// Directed bench for adder_scheduler (NREQ=4).
module tb_adder_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               Clk;
  logic               Reset_n;
  logic [NREQ-1:0]    Req_valid;
  logic [16*NREQ-1:0] Req_A;
  logic [16*NREQ-1:0] Req_B;
  logic [NREQ-1:0]    Req_grant;
  logic               Rsp_valid;
  logic               Rsp_ready;
  logic [IDW-1:0]     Rsp_id;
  logic [15:0]        Rsp_Sum;
  logic               Rsp_CO;
  logic               Busy;

  int n_checks = 0;
  int n_errors = 0;

  adder_scheduler #(.NREQ(NREQ)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Req_valid (Req_valid),
    .Req_A     (Req_A),
    .Req_B     (Req_B),
    .Req_grant (Req_grant),
    .Rsp_valid (Rsp_valid),
    .Rsp_ready (Rsp_ready),
    .Rsp_id    (Rsp_id),
    .Rsp_Sum   (Rsp_Sum),
    .Rsp_CO    (Rsp_CO),
    .Busy      (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        co;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_slot();
    @(posedge Clk);
    #1;
  endtask

  // Round-robin operand set: requester j presents A=0x1000*(j+1), B=j.
  function automatic logic [15:0] rr_sum(input int j);
    return 16'(16'h1000 * (j + 1) + j);
  endfunction

  initial begin
    int n_rsp;

    vecs[0] = '{2, 16'h1234, 16'h0001, 16'h1235, 1'b0};
    vecs[1] = '{1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{3, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[3] = '{0, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b0};
    vecs[4] = '{2, 16'hABCD, 16'h1111, 16'hBCDE, 1'b0};
    vecs[5] = '{3, 16'hF000, 16'h1001, 16'h0001, 1'b1};

    // Reset held with every requester asking.
    Reset_n   = 1'b0;
    Req_valid = '1;
    Req_A     = '0;
    Req_B     = '0;
    Rsp_ready = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_grant", 32'(Req_grant), 32'h0);
    check("rst_rsp_valid", 32'(Rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(Rsp_id), 32'h0);
    check("rst_rsp_sum", 32'(Rsp_Sum), 32'h0);
    check("rst_rsp_co", 32'(Rsp_CO), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);

    Reset_n = 1'b1;
    #1;
    check("rst_first_grant", 32'(Req_grant), 32'h1);
    Req_valid = '0;

    // Single adds with carry corners; one requester at a time.
    for (int v = 0; v < 6; v++) begin
      drive_slot();
      Req_A[16*vecs[v].id +: 16] = vecs[v].a;
      Req_B[16*vecs[v].id +: 16] = vecs[v].b;
      Req_valid = 4'(1 << vecs[v].id);
      Rsp_ready = 1'b1;
      @(negedge Clk);
      check($sformatf("vec%0d_grant", v), 32'(Req_grant), 32'(1 << vecs[v].id));
      drive_slot();
      Req_valid = '0;
      @(negedge Clk);
      check($sformatf("vec%0d_t1_valid", v), 32'(Rsp_valid), 32'h0);
      @(negedge Clk);
      check($sformatf("vec%0d_valid", v), 32'(Rsp_valid), 32'h1);
      check($sformatf("vec%0d_id", v), 32'(Rsp_id), 32'(vecs[v].id));
      check($sformatf("vec%0d_sum", v), 32'(Rsp_Sum), 32'(vecs[v].sum));
      check($sformatf("vec%0d_co", v), 32'(Rsp_CO), 32'(vecs[v].co));
    end

    // Round-robin, full throughput. Last grant above was to 3, so ptr is 0.
    for (int c = 0; c < 8; c++) begin
      drive_slot();
      if (c == 0) begin
        for (int j = 0; j < NREQ; j++) begin
          Req_A[16*j +: 16] = 16'(16'h1000 * (j + 1));
          Req_B[16*j +: 16] = 16'(j);
        end
      end
      Req_valid = (c < 6) ? 4'hF : 4'h0;
      Rsp_ready = 1'b1;
      @(negedge Clk);
      check($sformatf("rr%0d_grant", c), 32'(Req_grant), (c < 6) ? 32'(1 << (c % 4)) : 32'h0);
      if (c >= 2) begin
        check($sformatf("rr%0d_valid", c), 32'(Rsp_valid), 32'h1);
        check($sformatf("rr%0d_id", c), 32'(Rsp_id), 32'((c - 2) % 4));
        check($sformatf("rr%0d_sum", c), 32'(Rsp_Sum), 32'(rr_sum((c - 2) % 4)));
      end
    end

    // Backpressure: ptr is now 2. Two grants (2, 3), then stall.
    for (int c = 0; c < 5; c++) begin
      drive_slot();
      Req_valid = 4'hF;
      Rsp_ready = 1'b0;
      @(negedge Clk);
      if (c == 0) check("bp0_grant", 32'(Req_grant), 32'h4);
      else if (c == 1) check("bp1_grant", 32'(Req_grant), 32'h8);
      else begin
        check($sformatf("bp%0d_grant", c), 32'(Req_grant), 32'h0);
        check($sformatf("bp%0d_valid", c), 32'(Rsp_valid), 32'h1);
        check($sformatf("bp%0d_id", c), 32'(Rsp_id), 32'h2);
        check($sformatf("bp%0d_sum", c), 32'(Rsp_Sum), 32'(rr_sum(2)));
        check($sformatf("bp%0d_busy", c), 32'(Busy), 32'h1);
      end
    end
    drive_slot();
    Req_valid = '0;
    Rsp_ready = 1'b1;
    @(negedge Clk);
    check("drain0_id", 32'(Rsp_id), 32'h2);
    check("drain0_valid", 32'(Rsp_valid), 32'h1);
    @(negedge Clk);
    check("drain1_id", 32'(Rsp_id), 32'h3);
    check("drain1_sum", 32'(Rsp_Sum), 32'(rr_sum(3)));
    check("drain1_valid", 32'(Rsp_valid), 32'h1);
    @(negedge Clk);
    check("drain2_valid", 32'(Rsp_valid), 32'h0);
    check("drain2_busy", 32'(Busy), 32'h0);

    // Reset mid-flight: ptr is 0; fill S1/S2 with requesters 0 and 1.
    drive_slot();
    Req_valid = 4'hF;
    Rsp_ready = 1'b0;
    @(negedge Clk);
    check("mf0_grant", 32'(Req_grant), 32'h1);
    @(negedge Clk);
    check("mf1_grant", 32'(Req_grant), 32'h2);
    @(negedge Clk);
    check("mf2_grant", 32'(Req_grant), 32'h0);
    check("mf2_busy", 32'(Busy), 32'h1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("mf_rst_valid", 32'(Rsp_valid), 32'h0);
    check("mf_rst_busy", 32'(Busy), 32'h0);
    check("mf_rst_grant", 32'(Req_grant), 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    check("mf_rel_grant", 32'(Req_grant), 32'h1);
    Req_valid = 4'h1;
    Rsp_ready = 1'b1;
    drive_slot();
    Req_valid = '0;
    n_rsp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      if (Rsp_valid) begin
        n_rsp++;
        check("mf_rsp_id", 32'(Rsp_id), 32'h0);
        check("mf_rsp_sum", 32'(Rsp_Sum), 32'(rr_sum(0)));
      end
    end
    check("mf_rsp_count", 32'(n_rsp), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Round-robin scheduler that shares one 16-bit `ripple_adder` instance between `NREQ` requesters. Each requester presents an operand pair with a valid/grant handshake. The block registers the winning pair, runs it through the adder, and returns the registered sum, carry-out and requester ID on a single valid/ready response channel. It sits between the requesting datapath blocks and the adder, and is the only block that drives the adder's operand inputs.

## Interface

Parameters:
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID; derived, do not override.

Ports:
- `Clk` in 1: single clock; all state is updated on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Req_valid` in NREQ: bit i is requester i's operand-valid.
- `Req_A` in 16*NREQ: requester i's A operand is in bits [16i+15:16i].
- `Req_B` in 16*NREQ: requester i's B operand, packed the same way as `Req_A`.
- `Req_grant` out NREQ: one-hot or zero. Bit i high means requester i's operands are accepted this cycle.
- `Rsp_valid` out 1: the response registers hold a result.
- `Rsp_ready` in 1: the consumer accepts the response this cycle.
- `Rsp_id` out IDW: the requester that owns the current result.
- `Rsp_Sum` out 16: (A+B) mod 2^16.
- `Rsp_CO` out 1: carry out of bit 15.
- `Busy` out 1: high when S1 or S2 is occupied.

## Operation

- Two-stage pipeline:
  - S1 is the operand register: `s1_v`, `s1_id`, `s1_A`, `s1_B`.
  - S2 is the response register: `Rsp_valid`, `Rsp_id`, `Rsp_Sum`, `Rsp_CO`.
  - The adder is combinational between S1 and S2, with carry-in fixed at 0.
- Advance rules, all combinational:
  - `s2_free = !Rsp_valid | Rsp_ready`
  - `s1_adv = s1_v & s2_free`
  - `s1_free = !s1_v | s1_adv`
- S2 load:
  - If `s1_adv`, S2 takes the adder output and `s1_id`, and `Rsp_valid` goes to 1.
  - Else if `Rsp_ready`, `Rsp_valid` goes to 0.
  - Otherwise S2 holds.
- Arbitration:
  - When `s1_free` and any `Req_valid` bit is high, grant exactly one requester.
  - The winner is the first valid index found searching upward from pointer `ptr`, wrapping from NREQ-1 to 0.
  - The granted operands load into S1 with `s1_v`=1. Otherwise `s1_v` goes to 0 if `s1_adv`, or holds.
- Pointer:
  - On a grant to requester w, `ptr` becomes (w+1) mod NREQ.
  - With no grant, `ptr` is unchanged.
  - The wrap is correct for NREQ values that are not powers of two.
- `Req_grant` is a Mealy output: it depends on `Req_valid`, `ptr`, S1/S2 occupancy and `Rsp_ready`.
- Requesters must hold `Req_valid`, `Req_A` and `Req_B` stable until granted. A requester may drop valid before being granted; no grant is then issued to it.
- While `Rsp_valid` is high and `Rsp_ready` is low, `Rsp_id`, `Rsp_Sum` and `Rsp_CO` stay stable.
- No request is lost or duplicated. Responses leave in grant order.

## Timing

- Reset (`Reset_n` low, asynchronous):
  - `Rsp_valid`=0, `Rsp_id`=0, `Rsp_Sum`=0, `Rsp_CO`=0, `Busy`=0.
  - `s1_v`=0 and `ptr`=0.
  - `Req_grant` is forced to 0 while `Reset_n` is low.
- Reset asserted mid-operation: S1 and S2 contents are discarded immediately and no response is produced for them.
- Latency: a grant in cycle t produces `Rsp_valid` from cycle t+2.
- Throughput: one operation per cycle while `Rsp_ready` stays high.
- Backpressure:
  - With `Rsp_ready` low, at most two operations are in flight (S1 and S2).
  - After that, `Req_grant` is 0 until S2 drains.
- Simultaneous events:
  - A response accepted in the same cycle as S1 advancing and a new grant: all three transfers occur on that edge.
  - Throughput is not lost on this path.
- `Busy` = `s1_v | Rsp_valid`. It is a registered-state function with no combinational path from the inputs.

## Test plan

- Reset check:
  - Hold `Reset_n` low with all `Req_valid`=1. Require `Req_grant`=0, `Rsp_valid`=0 and all outputs 0.
  - Release reset. The first grant goes to requester 0.
- Single add:
  - Requester 2 sends A=0x1234, B=0x0001, with `Rsp_ready`=1.
  - Require `Req_grant`=0100 in cycle t.
  - In cycle t+2 require `Rsp_valid`=1, `Rsp_id`=2, `Rsp_Sum`=0x1235, `Rsp_CO`=0.
- Carry cases:
  - 0xFFFF+0x0001 gives Sum 0x0000, CO 1.
  - 0x8000+0x8000 gives Sum 0x0000, CO 1.
  - 0x7FFF+0x0000 gives Sum 0x7FFF, CO 0.
- Round-robin:
  - All 4 requesters continuously valid, `Rsp_ready`=1.
  - Grants go to 0,1,2,3,0,1 on consecutive cycles.
  - Responses appear back-to-back with `Rsp_id` 0,1,2,3,0,1.
- Backpressure:
  - All requesters valid, `Rsp_ready`=0.
  - Exactly two grants occur, then `Req_grant`=0 and the response outputs stay stable.
  - Raise `Rsp_ready`. The pipeline drains in grant order with no lost or duplicated IDs.
- Reset mid-flight:
  - With S1 and S2 full, pulse `Reset_n` low asynchronously, between clock edges.
  - `Rsp_valid` and `Busy` drop to 0 immediately.
  - After release the next grant goes to requester 0 and the discarded operations never appear on the response channel.
